branch_resolve: RTL and testbench

// Upstream feeder of the SIMT branch divergence unit. Holds per-thread NZP condition flags

---
 rtl/branch_resolve.sv | 129 ++++++++++++
 tb/tb_branch_resolve.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch condition evaluation ahead of the SIMT divergence unit.
// Holds per-thread NZP flags and issues a one-cycle branch strobe.
module branch_resolve #(
    parameter int THREADS_PER_WARP = 8,
    parameter int PC_BITS          = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          cmp_valid,
    input  logic [THREADS_PER_WARP-1:0]   cmp_thread_mask,
    input  logic [3*THREADS_PER_WARP-1:0] cmp_nzp,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic                          instr_is_branch,
    input  logic [PC_BITS-1:0]            instr_pc,
    input  logic [2:0]                    instr_cond,
    input  logic [PC_BITS-1:0]            instr_target,
    input  logic [THREADS_PER_WARP-1:0]   active_mask,
    input  logic                          div_stall,
    output logic                          branch_instruction,
    output logic [THREADS_PER_WARP-1:0]   branch_taken,
    output logic [PC_BITS-1:0]            branch_target,
    output logic [PC_BITS-1:0]            fallthrough_pc,
    output logic [PC_BITS-1:0]            reconverge_pc,
    output logic                          busy
);

    localparam int T = THREADS_PER_WARP;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3*T-1:0]     nzp_q;
    logic [PC_BITS-1:0] lat_pc;
    logic [PC_BITS-1:0] lat_target;
    logic [2:0]         lat_cond;
    logic [T-1:0]       lat_active;

    logic               accept;
    logic [T-1:0]       taken_c;
    logic [PC_BITS-1:0] ft_c;
    logic [PC_BITS-1:0] rc_c;

    assign instr_ready        = (state == IDLE) & enable;
    assign accept             = instr_valid & instr_ready & instr_is_branch;
    assign branch_instruction = (state == ISSUE) & enable;
    assign busy               = (state != IDLE);

    // Next-state logic; the FSM only advances while enabled
    always_comb begin
        state_nxt = state;
        if (enable) begin
            unique case (state)
                IDLE:  if (accept) state_nxt = EVAL;
                EVAL:  state_nxt = ISSUE;
                ISSUE: state_nxt = WAIT;
                WAIT:  if (!div_stall) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Per-thread NZP flags, written by the compare stage in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            nzp_q <= '0;
        end else if (enable && cmp_valid) begin
            for (int i = 0; i < T; i++) begin
                if (cmp_thread_mask[i])
                    nzp_q[3*i +: 3] <= cmp_nzp[3*i +: 3];
            end
        end
    end

    // Capture the branch operands at the handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_pc     <= '0;
            lat_target <= '0;
            lat_cond   <= '0;
            lat_active <= '0;
        end else if (accept) begin
            lat_pc     <= instr_pc;
            lat_target <= instr_target;
            lat_cond   <= instr_cond;
            lat_active <= active_mask;
        end
    end

    // Per-thread condition test and PC arithmetic on latched operands
    always_comb begin
        taken_c = '0;
        for (int i = 0; i < T; i++)
            taken_c[i] = lat_active[i] & (|(nzp_q[3*i +: 3] & lat_cond));
        ft_c = lat_pc + {{(PC_BITS-1){1'b0}}, 1'b1};
        // forward branch reconverges at its target, loops at fall-through
        rc_c = (lat_target > lat_pc) ? lat_target : ft_c;
    end

    // Result registers, loaded in EVAL and held until the next EVAL
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_taken   <= '0;
            branch_target  <= '0;
            fallthrough_pc <= '0;
            reconverge_pc  <= '0;
        end else if (enable && state == EVAL) begin
            branch_taken   <= taken_c;
            branch_target  <= lat_target;
            fallthrough_pc <= ft_c;
            reconverge_pc  <= rc_c;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: random compare writes and
// branches checked against a thread-level reference model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cmp_valid;
    logic [7:0]  cmp_thread_mask;
    logic [23:0] cmp_nzp;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_is_branch;
    logic [7:0]  instr_pc;
    logic [2:0]  instr_cond;
    logic [7:0]  instr_target;
    logic [7:0]  active_mask;
    logic        div_stall;
    logic        branch_instruction;
    logic [7:0]  branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  fallthrough_pc;
    logic [7:0]  reconverge_pc;
    logic        busy;

    branch_resolve #(.THREADS_PER_WARP(8), .PC_BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .cmp_valid(cmp_valid),
        .cmp_thread_mask(cmp_thread_mask),
        .cmp_nzp(cmp_nzp),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_is_branch(instr_is_branch),
        .instr_pc(instr_pc),
        .instr_cond(instr_cond),
        .instr_target(instr_target),
        .active_mask(active_mask),
        .div_stall(div_stall),
        .branch_instruction(branch_instruction),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .fallthrough_pc(fallthrough_pc),
        .reconverge_pc(reconverge_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] taken;
        logic [7:0] target;
        logic [7:0] ft;
        logic [7:0] rc;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] mflags[8];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         npush = 0;
    int         nstrobe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected branch
    always @(negedge clk) begin
        if (!reset && branch_instruction === 1'b1) begin
            exp_t e;
            nstrobe++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("taken", branch_taken, e.taken);
                chk("target", branch_target, e.target);
                chk("fallthrough", fallthrough_pc, e.ft);
                chk("reconverge", reconverge_pc, e.rc);
            end
        end
    end

    function automatic void model_write(input logic [7:0] m,
                                        input logic [23:0] z);
        for (int i = 0; i < 8; i++)
            if (m[i]) mflags[i] = z[3*i +: 3];
    endfunction

    function automatic exp_t model_branch(input logic [7:0] pc,
                                          input logic [2:0] cond,
                                          input logic [7:0] tgt,
                                          input logic [7:0] act);
        exp_t e;
        int   ft;
        e.taken = '0;
        for (int i = 0; i < 8; i++)
            if (act[i] && (mflags[i] & cond) != 3'b000) e.taken[i] = 1'b1;
        ft       = (int'(pc) + 1) % 256;
        e.ft     = ft[7:0];
        e.target = tgt;
        e.rc     = (int'(tgt) > int'(pc)) ? tgt : ft[7:0];
        e.cyc    = 0;
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_write(input logic [7:0] m, input logic [23:0] z);
        cmp_valid       = 1'b1;
        cmp_thread_mask = m;
        cmp_nzp         = z;
        model_write(m, z);
        step();
        cmp_valid = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        ok = (instr_ready === 1'b1);
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    task automatic do_branch(input logic [7:0] pc, input logic [2:0] cond,
                             input logic [7:0] tgt, input logic [7:0] act,
                             input bit acc_wr, input bit ev_wr,
                             input int en_low, input int stall);
        exp_t        e;
        bit          ok;
        logic [7:0]  m;
        logic [23:0] z;
        instr_valid     = 1'b1;
        instr_is_branch = 1'b1;
        instr_pc        = pc;
        instr_cond      = cond;
        instr_target    = tgt;
        active_mask     = act;
        if (acc_wr) begin
            m = 8'($urandom);
            z = 24'($urandom);
            cmp_valid       = 1'b1;
            cmp_thread_mask = m;
            cmp_nzp         = z;
            model_write(m, z);
        end
        wait_ready(ok);
        if (!ok) begin
            instr_valid = 1'b0;
            cmp_valid   = 1'b0;
            return;
        end
        e     = model_branch(pc, cond, tgt, act);
        e.cyc = cyc + 2 + en_low;
        sb.push_back(e);
        npush++;
        step();
        instr_valid  = 1'b0;
        cmp_valid    = 1'b0;
        instr_pc     = 8'($urandom);
        instr_target = 8'($urandom);
        instr_cond   = 3'($urandom);
        active_mask  = 8'($urandom);
        m = 8'($urandom);
        z = 24'($urandom);
        if (ev_wr) begin
            cmp_valid       = 1'b1;
            cmp_thread_mask = m;
            cmp_nzp         = z;
        end
        step();
        cmp_valid = 1'b0;
        if (ev_wr) model_write(m, z);
        if (en_low > 0) begin
            enable = 1'b0;
            repeat (en_low) step();
            enable = 1'b1;
        end
        div_stall = (stall > 0);
        step();
        for (int k = 0; k < stall; k++) begin
            chk("ready_in_wait", instr_ready, 0);
            chk("busy_in_wait", busy, 1);
            chk("taken_hold", branch_taken, e.taken);
            step();
        end
        div_stall = 1'b0;
    endtask

    task automatic non_branch;
        bit ok;
        instr_valid     = 1'b1;
        instr_is_branch = 1'b0;
        wait_ready(ok);
        step();
        instr_valid = 1'b0;
        chk("nonbranch_idle", busy, 0);
        chk("nonbranch_ready", instr_ready, 1);
    endtask

    initial begin
        reset           = 1'b1;
        enable          = 1'b1;
        cmp_valid       = 1'b0;
        cmp_thread_mask = '0;
        cmp_nzp         = '0;
        instr_valid     = 1'b0;
        instr_is_branch = 1'b0;
        instr_pc        = '0;
        instr_cond      = '0;
        instr_target    = '0;
        active_mask     = '0;
        div_stall       = 1'b0;
        for (int i = 0; i < 8; i++) mflags[i] = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_strobe", branch_instruction, 0);
        chk("rst_taken", branch_taken, 0);
        chk("rst_target", branch_target, 0);
        chk("rst_ft", fallthrough_pc, 0);
        chk("rst_rc", reconverge_pc, 0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        step();

        do_branch(8'd3, 3'b111, 8'd9, 8'hFF, 0, 0, 0, 0);
        cmp_write(8'hFF, {8{3'b010}});
        do_branch(8'd10, 3'b010, 8'd20, 8'hFF, 0, 0, 0, 0);
        cmp_write(8'hFF, {{4{3'b001}}, {4{3'b100}}});
        do_branch(8'd30, 3'b100, 8'd5, 8'h3F, 0, 0, 0, 0);
        do_branch(8'hFF, 3'b111, 8'h10, 8'hA5, 0, 0, 0, 0);
        do_branch(8'd40, 3'b000, 8'd40, 8'hFF, 0, 0, 0, 3);
        do_branch(8'd50, 3'b001, 8'd60, 8'hFF, 0, 1, 2, 0);
        do_branch(8'd51, 3'b111, 8'd70, 8'hFF, 0, 0, 0, 0);
        non_branch();

        // abort a branch in flight with reset
        instr_valid     = 1'b1;
        instr_is_branch = 1'b1;
        begin
            bit ok;
            wait_ready(ok);
        end
        step();
        instr_valid = 1'b0;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mflags[i] = 3'b000;
        chk("abort_busy", busy, 0);
        chk("abort_taken", branch_taken, 0);
        do_branch(8'd7, 3'b111, 8'd8, 8'hFF, 0, 0, 0, 0);

        repeat (40) begin
            if ($urandom_range(0, 1) == 1)
                cmp_write(8'($urandom), 24'($urandom));
            if ($urandom_range(0, 7) == 0) non_branch();
            do_branch(8'($urandom), 3'($urandom), 8'($urandom),
                      8'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        repeat (5) step();
        chk("sb_empty", sb.size(), 0);
        chk("strobe_count", nstrobe, npush);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
